// File: rtl/ycbcr_skin_centroid_if.sv
// Video stream bundle for the skin-mask centroid block: YCbCr in, binarised RGB plus centroid out.
interface ycbcr_skin_centroid_if;
    logic        de_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [26:0] pixel_in;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;
    logic [23:0] pixel_out;
    logic [10:0] centroid_x;
    logic [10:0] centroid_y;
    logic        centroid_found;
    logic        centroid_valid;

    modport slave (
        input  de_in, hsync_in, vsync_in, pixel_in,
        output de_out, hsync_out, vsync_out, pixel_out,
               centroid_x, centroid_y, centroid_found, centroid_valid
    );

    modport master (
        output de_in, hsync_in, vsync_in, pixel_in,
        input  de_out, hsync_out, vsync_out, pixel_out,
               centroid_x, centroid_y, centroid_found, centroid_valid
    );
endinterface

// File: rtl/ycbcr_skin_centroid.sv
// Skin classifier on a YCbCr stream: per-frame mask centroid via a bit-serial divider,
// plus a binarised RGB stream with a red crosshair at the last centroid.
module ycbcr_skin_centroid #(
    parameter int unsigned CB_MIN = 77,
    parameter int unsigned CB_MAX = 127,
    parameter int unsigned CR_MIN = 133,
    parameter int unsigned CR_MAX = 173
) (
    input  logic                  clk,
    input  logic                  rst,
    ycbcr_skin_centroid_if.slave  vid
);

    localparam int unsigned XW = 11;
    localparam int unsigned CW = 21;
    localparam int unsigned SW = 32;
    localparam int unsigned PW = 24;
    localparam int unsigned BW = 5;

    localparam logic [XW-1:0] XY_MAX  = '1;
    localparam logic [BW-1:0] BIT_END = BW'(SW - 1);
    localparam logic [PW-1:0] RGB_RED   = 24'hFF0000;
    localparam logic [PW-1:0] RGB_WHITE = 24'hFFFFFF;

    typedef enum logic [1:0] {IDLE, DIVX, DIVY, DONE} state_e;

    state_e         state_q, state_d;
    logic           de_out_q, hs_out_q, vs_out_q;
    logic           vs_blk_q;
    logic [PW-1:0]  pix_q, pix_d;
    logic [XW-1:0]  x_q, x_d, y_q, y_d;
    logic [CW-1:0]  cnt_q, cnt_d, snap_cnt_q, snap_cnt_d;
    logic [SW-1:0]  sx_q, sx_d, sy_q, sy_d, snap_sx_q, snap_sx_d, snap_sy_q, snap_sy_d;
    logic           start_q, start_d;
    logic [SW-1:0]  num_q, num_d, quo_q, quo_d;
    logic [CW-1:0]  rem_q, rem_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [XW-1:0]  qx_q, qx_d, qy_q, qy_d;
    logic [XW-1:0]  cx_q, cx_d, cy_q, cy_d;
    logic           found_q, found_d, valid_q, valid_d;

    logic [8:0]     cb_c, cr_c;
    logic           mask_c, hit_c, frame_edge_c, de_fall_c;
    logic [CW:0]    trial_c;
    logic           ge_c;
    logic [CW-1:0]  rem_nx_c;
    logic [SW-1:0]  quo_nx_c, num_nx_c;
    logic           unused_y;

    assign unused_y = ^vid.pixel_in[26:18];

    // Signed window test: a set sign bit can never fall inside a positive window.
    assign cb_c   = vid.pixel_in[17:9];
    assign cr_c   = vid.pixel_in[8:0];
    assign mask_c = !cb_c[8] && (cb_c[7:0] >= 8'(CB_MIN)) && (cb_c[7:0] <= 8'(CB_MAX)) &&
                    !cr_c[8] && (cr_c[7:0] >= 8'(CR_MIN)) && (cr_c[7:0] <= 8'(CR_MAX));
    assign hit_c  = vid.de_in && mask_c;

    // vs_blk_q masks a vsync that was already high when reset released.
    assign frame_edge_c = vid.vsync_in && !vs_out_q && !vs_blk_q;
    assign de_fall_c    = de_out_q && !vid.de_in;

    // One restoring-division step on the current dividend MSB.
    assign trial_c  = {rem_q, num_q[SW-1]};
    assign ge_c     = trial_c >= {1'b0, snap_cnt_q};
    assign rem_nx_c = ge_c ? CW'(trial_c - {1'b0, snap_cnt_q}) : trial_c[CW-1:0];
    assign quo_nx_c = {quo_q[SW-2:0], ge_c};
    assign num_nx_c = {num_q[SW-2:0], 1'b0};

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        cnt_d = cnt_q;
        sx_d  = sx_q;
        sy_d  = sy_q;
        snap_cnt_d = snap_cnt_q;
        snap_sx_d  = snap_sx_q;
        snap_sy_d  = snap_sy_q;
        start_d = 1'b0;

        if (frame_edge_c) begin
            x_d = '0;
            y_d = '0;
            snap_cnt_d = cnt_q;
            snap_sx_d  = sx_q;
            snap_sy_d  = sy_q;
            start_d    = 1'b1;
            cnt_d = hit_c ? CW'(1) : '0;
            sx_d  = hit_c ? SW'(x_q) : '0;
            sy_d  = hit_c ? SW'(y_q) : '0;
        end else begin
            if (hit_c) begin
                cnt_d = cnt_q + CW'(1);
                sx_d  = sx_q + SW'(x_q);
                sy_d  = sy_q + SW'(y_q);
            end
            if (vid.de_in) begin
                x_d = (x_q == XY_MAX) ? x_q : x_q + XW'(1);
            end else if (de_fall_c) begin
                x_d = '0;
                y_d = (y_q == XY_MAX) ? y_q : y_q + XW'(1);
            end
        end
    end

    // Divider sequencing; a new frame edge always pre-empts whatever is in flight.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        bit_d   = bit_q;
        qx_d    = qx_q;
        qy_d    = qy_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        found_d = found_q;
        valid_d = 1'b0;

        if (frame_edge_c) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_q) begin
                        num_d = snap_sx_q;
                        rem_d = '0;
                        quo_d = '0;
                        bit_d = '0;
                        state_d = (snap_cnt_q == '0) ? DONE : DIVX;
                    end
                end
                DIVX: begin
                    num_d = num_nx_c;
                    rem_d = rem_nx_c;
                    quo_d = quo_nx_c;
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BIT_END) begin
                        qx_d  = quo_nx_c[XW-1:0];
                        num_d = snap_sy_q;
                        rem_d = '0;
                        quo_d = '0;
                        bit_d = '0;
                        state_d = DIVY;
                    end
                end
                DIVY: begin
                    num_d = num_nx_c;
                    rem_d = rem_nx_c;
                    quo_d = quo_nx_c;
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BIT_END) begin
                        qy_d    = quo_nx_c[XW-1:0];
                        state_d = DONE;
                    end
                end
                DONE: begin
                    valid_d = 1'b1;
                    if (snap_cnt_q != '0) begin
                        cx_d    = qx_q;
                        cy_d    = qy_q;
                        found_d = 1'b1;
                    end else begin
                        found_d = 1'b0;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Overlay uses the centroid registers as they stand when the pixel arrives.
    always_comb begin
        pix_d = '0;
        if (vid.de_in) begin
            if (found_q && ((x_q == cx_q) || (y_q == cy_q))) begin
                pix_d = RGB_RED;
            end else if (mask_c) begin
                pix_d = RGB_WHITE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de_out_q   <= 1'b0;
            hs_out_q   <= 1'b0;
            vs_out_q   <= 1'b0;
            vs_blk_q   <= vid.vsync_in;
            pix_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            cnt_q      <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            snap_cnt_q <= '0;
            snap_sx_q  <= '0;
            snap_sy_q  <= '0;
            start_q    <= 1'b0;
            num_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            bit_q      <= '0;
            qx_q       <= '0;
            qy_q       <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            found_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            de_out_q   <= vid.de_in;
            hs_out_q   <= vid.hsync_in;
            vs_out_q   <= vid.vsync_in;
            vs_blk_q   <= vs_blk_q && vid.vsync_in;
            pix_q      <= pix_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            snap_cnt_q <= snap_cnt_d;
            snap_sx_q  <= snap_sx_d;
            snap_sy_q  <= snap_sy_d;
            start_q    <= start_d;
            num_q      <= num_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            bit_q      <= bit_d;
            qx_q       <= qx_d;
            qy_q       <= qy_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            found_q    <= found_d;
            valid_q    <= valid_d;
        end
    end

    assign vid.de_out         = de_out_q;
    assign vid.hsync_out      = hs_out_q;
    assign vid.vsync_out      = vs_out_q;
    assign vid.pixel_out      = pix_q;
    assign vid.centroid_x     = cx_q;
    assign vid.centroid_y     = cy_q;
    assign vid.centroid_found = found_q;
    assign vid.centroid_valid = valid_q;

endmodule

// File: tb/tb_ycbcr_skin_centroid.sv
// Randomised and directed frames against a frame-level reference model of mask, overlay and centroid.
module tb_ycbcr_skin_centroid;

    localparam int W = 112;
    localparam int H = 24;
    localparam logic [26:0] SKIN = {9'd40, 9'd100, 9'd150};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ycbcr_skin_centroid_if vif ();
    ycbcr_skin_centroid dut (.clk(clk), .rst(rst), .vid(vif));

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct {
        int          cyc;
        logic        found;
        logic [10:0] x;
        logic [10:0] y;
    } ev_t;
    ev_t ev_q[$];

    logic [17:0] thr_tbl [10];
    int rx0, rx1, ry0, ry1;

    // Reference model state
    int          cyc = 0;
    bit          started = 0;
    logic        m_de, m_hs, m_vs, m_valid, m_found;
    logic [23:0] m_pix;
    int          m_cx, m_cy, mx, my;
    bit          prev_de, prev_vs, blk, pend, mk, vedge;
    longint      acc_c, acc_x, acc_y, p_c, p_x, p_y;
    int          due, last_edge;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit is_skin(logic [26:0] p);
        logic signed [8:0] cb9;
        logic signed [8:0] cr9;
        int cb;
        int cr;
        cb9 = p[17:9];
        cr9 = p[8:0];
        cb  = cb9;
        cr  = cr9;
        return (cb >= 77) && (cb <= 127) && (cr >= 133) && (cr <= 173);
    endfunction

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (rst) begin
            {m_de, m_hs, m_vs, m_valid, m_found} = '0;
            m_pix = '0;
            m_cx = 0; m_cy = 0; mx = 0; my = 0;
            prev_de = 0; prev_vs = 0; pend = 0;
            blk = vif.vsync_in;
            acc_c = 0; acc_x = 0; acc_y = 0;
        end else begin
            mk    = vif.de_in && is_skin(vif.pixel_in);
            m_de  = vif.de_in;
            m_hs  = vif.hsync_in;
            m_vs  = vif.vsync_in;
            if (!vif.de_in)                                  m_pix = 24'h000000;
            else if (m_found && (mx == m_cx || my == m_cy))  m_pix = 24'hFF0000;
            else if (mk)                                     m_pix = 24'hFFFFFF;
            else                                             m_pix = 24'h000000;
            m_valid = 0;
            vedge = vif.vsync_in && !prev_vs && !blk;
            blk   = blk && vif.vsync_in;
            if (vedge) begin
                pend = 1;
                due  = cyc + ((acc_c == 0) ? 2 : 66);
                p_c = acc_c; p_x = acc_x; p_y = acc_y;
                last_edge = cyc;
                acc_c = mk ? 1 : 0;
                acc_x = mk ? mx : 0;
                acc_y = mk ? my : 0;
                mx = 0; my = 0;
            end else begin
                if (pend && cyc == due) begin
                    m_valid = 1;
                    pend = 0;
                    if (p_c != 0) begin
                        m_cx = int'(p_x / p_c) & 2047;
                        m_cy = int'(p_y / p_c) & 2047;
                        m_found = 1;
                    end else begin
                        m_found = 0;
                    end
                end
                if (mk) begin
                    acc_c += 1; acc_x += mx; acc_y += my;
                end
                if (vif.de_in) begin
                    if (mx < 2047) mx++;
                end else if (prev_de) begin
                    mx = 0;
                    if (my < 2047) my++;
                end
            end
            prev_de = vif.de_in;
            prev_vs = vif.vsync_in;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check_eq("video", {vif.de_out, vif.hsync_out, vif.vsync_out, vif.pixel_out},
                     {m_de, m_hs, m_vs, m_pix});
            check_eq("centroid", {vif.centroid_valid, vif.centroid_found, vif.centroid_x, vif.centroid_y},
                     {m_valid, m_found, 11'(m_cx), 11'(m_cy)});
            if (vif.centroid_valid)
                ev_q.push_back('{cyc, vif.centroid_found, vif.centroid_x, vif.centroid_y});
        end
    end

    task automatic drive(input logic de, input logic hs, input logic vs, input logic [26:0] p);
        vif.de_in = de; vif.hsync_in = hs; vif.vsync_in = vs; vif.pixel_in = p;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] pix_of(int kind, int x, int y);
        logic [17:0] t;
        case (kind)
            1: return (x == 10 && y == 5) ? SKIN : 27'd0;
            2: return (x >= 100 && x <= 103 && y >= 20 && y <= 21) ? SKIN : 27'd0;
            3: return 27'd0;
            4: begin
                if (y == 0 && x < 10) begin
                    t = thr_tbl[x];
                    return {9'd60, t};
                end
                return 27'd0;
            end
            default: begin
                if (x >= rx0 && x <= rx1 && y >= ry0 && y <= ry1)
                    return {9'($urandom_range(0, 511)), 9'($urandom_range(65, 140)), 9'($urandom_range(120, 185))};
                return 27'($urandom);
            end
        endcase
    endfunction

    task automatic vsync_pulse(output int e);
        repeat (3) drive(1'b0, 1'b0, 1'b1, 27'd0);
        e = last_edge;
    endtask

    task automatic content(input int kind);
        int hb;
        rx0 = $urandom_range(0, 100);
        rx1 = rx0 + $urandom_range(0, 10);
        ry0 = $urandom_range(0, 20);
        ry1 = ry0 + $urandom_range(0, 3);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 27'd0);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) drive(1'b1, 1'b0, 1'b0, pix_of(kind, x, y));
            hb = $urandom_range(3, 6);
            repeat (hb) drive(1'b0, 1'b1, 1'b0, 27'd0);
        end
    endtask

    task automatic check_event(input string tag, input int e, input int lat,
                               input logic found, input int x, input int y);
        ev_t ev;
        check_eq({tag, "_count"}, 64'(ev_q.size()), 64'd1);
        if (ev_q.size() > 0) begin
            ev = ev_q.pop_front();
            check_eq({tag, "_latency"}, 64'(ev.cyc - e), 64'(lat));
            check_eq({tag, "_value"}, {ev.found, ev.x, ev.y}, {found, 11'(x), 11'(y)});
        end
        ev_q.delete();
    endtask

    initial begin
        int e;
        int e2;
        thr_tbl[0] = {9'd77,  9'd150};
        thr_tbl[1] = {9'd127, 9'd150};
        thr_tbl[2] = {9'd100, 9'd133};
        thr_tbl[3] = {9'd100, 9'd173};
        thr_tbl[4] = {9'd76,  9'd150};
        thr_tbl[5] = {9'd128, 9'd150};
        thr_tbl[6] = {9'd100, 9'd132};
        thr_tbl[7] = {9'd100, 9'd174};
        thr_tbl[8] = {9'h1F0, 9'd150};
        thr_tbl[9] = {9'd100, 9'h1F0};

        rst = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 1'b1, 27'd0);
        rst = 1'b0;
        repeat (6) drive(1'b0, 1'b0, 1'b1, 27'd0);
        check_eq("held_vsync_no_pulse", 64'(ev_q.size()), 64'd0);
        check_eq("reset_centroid", {vif.centroid_valid, vif.centroid_found, vif.centroid_x, vif.centroid_y}, 64'd0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 27'd0);

        vsync_pulse(e); content(1); check_event("first_empty", e, 2, 1'b0, 0, 0);
        vsync_pulse(e); content(2); check_event("single_px", e, 66, 1'b1, 10, 5);
        vsync_pulse(e); content(4); check_event("box", e, 66, 1'b1, 101, 20);
        vsync_pulse(e); content(3); check_event("thresholds", e, 66, 1'b1, 1, 0);
        vsync_pulse(e); content(0); check_event("empty", e, 2, 1'b0, 1, 0);

        // Second edge lands 20 cycles after the first, with four skin pixels in between.
        vsync_pulse(e);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 27'd0);
        repeat (4) drive(1'b1, 1'b0, 1'b0, SKIN);
        repeat (11) drive(1'b0, 1'b0, 1'b0, 27'd0);
        vsync_pulse(e2);
        check_eq("abort_spacing", 64'(e2 - e), 64'd20);
        content(0);
        check_event("abort", e2, 66, 1'b1, 1, 0);

        for (int k = 0; k < 4; k++) begin
            vsync_pulse(e);
            content(0);
        end

        vsync_pulse(e); content(2); ev_q.delete();
        vsync_pulse(e);
        repeat (27) drive(1'b0, 1'b0, 1'b0, 27'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 27'd0);
        check_eq("mid_div_reset_outs",
                 {vif.de_out, vif.hsync_out, vif.vsync_out, vif.pixel_out,
                  vif.centroid_valid, vif.centroid_found, vif.centroid_x, vif.centroid_y}, 64'd0);
        rst = 1'b0;
        repeat (80) drive(1'b0, 1'b0, 1'b0, 27'd0);
        check_eq("mid_div_reset_no_pulse", 64'(ev_q.size()), 64'd0);

        vsync_pulse(e); content(0);
        vsync_pulse(e); content(2);
        vsync_pulse(e); content(0);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 27'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
